// File: rtl/regfile_bank_if.sv
// Bus bundle for regfile_bank: write port, two read ports, bulk-clear handshake.
interface regfile_bank_if #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16
);
  localparam int AW = $clog2(DEPTH);

  logic             we;
  logic [AW-1:0]    waddr;
  logic [WIDTH-1:0] wdata;
  logic [AW-1:0]    raddr_a;
  logic [WIDTH-1:0] rdata_a;
  logic [AW-1:0]    raddr_b;
  logic [WIDTH-1:0] rdata_b;
  logic             clr;
  logic             busy;

  modport master (
    output we, waddr, wdata, raddr_a, raddr_b, clr,
    input  rdata_a, rdata_b, busy
  );

  modport slave (
    input  we, waddr, wdata, raddr_a, raddr_b, clr,
    output rdata_a, rdata_b, busy
  );
endinterface

// File: rtl/regfile_bank.sv
// Register bank: 1 write / 2 registered read ports, optional hardwired-zero entry 0,
// sequenced bulk clear. Define REGFILE_BYPASS_EN to forward same-cycle writes to reads.
module regfile_bank #(
  parameter int WIDTH   = 32,
  parameter int DEPTH   = 16,
  parameter int ZERO_R0 = 1
) (
  input  logic           clk,
  input  logic           rst,
  regfile_bank_if.slave  bus
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t           state, state_d;
  logic [AW-1:0]    ptr, ptr_d;
  logic             busy_d;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             wr_ok, fwd_a, fwd_b;

  // Non-power-of-two DEPTH leaves addresses that map to no entry.
  function automatic logic live(input logic [AW-1:0] a);
    return ({1'b0, a} < (AW+1)'(DEPTH)) && !((ZERO_R0 != 0) && (a == '0));
  endfunction

  function automatic logic [WIDTH-1:0] rd_word(input logic [AW-1:0] a);
    return live(a) ? mem[a] : '0;
  endfunction

  assign wr_ok = bus.we && !bus.busy && !bus.clr && live(bus.waddr);

`ifdef REGFILE_BYPASS_EN
  assign fwd_a = wr_ok && (bus.raddr_a == bus.waddr);
  assign fwd_b = wr_ok && (bus.raddr_b == bus.waddr);
`else
  assign fwd_a = 1'b0;
  assign fwd_b = 1'b0;
`endif

  always_comb begin
    state_d = state;
    ptr_d   = ptr;
    case (state)
      IDLE: if (bus.clr) begin
        state_d = SWEEP;
        ptr_d   = '0;
      end
      SWEEP: begin
        ptr_d = ptr + 1'b1;
        if (ptr == AW'(DEPTH-1)) begin
          state_d = IDLE;
          ptr_d   = '0;
        end
      end
      default: state_d = IDLE;
    endcase
    busy_d = (state_d == SWEEP);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= '0;
      bus.busy <= 1'b0;
    end else begin
      state    <= state_d;
      ptr      <= ptr_d;
      bus.busy <= busy_d;
    end
  end

  // Sweep owns the array while busy; writes are only accepted when idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
    end else if (state == SWEEP) begin
      mem[ptr] <= '0;
    end else if (wr_ok) begin
      mem[bus.waddr] <= bus.wdata;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.rdata_a <= '0;
      bus.rdata_b <= '0;
    end else begin
      bus.rdata_a <= fwd_a ? bus.wdata : rd_word(bus.raddr_a);
      bus.rdata_b <= fwd_b ? bus.wdata : rd_word(bus.raddr_b);
    end
  end
endmodule
